// File: rtl/md5_core_if.sv
// rtl/md5_core_if.sv - start/txt request and busy/valid/hash response bundle of one cracker lane
interface md5_core_if;
    logic         start;
    logic [63:0]  txt;
    logic         busy;
    logic         valid;
    logic [127:0] hash;

    modport master (output start, output txt, input busy, input valid, input hash);
    modport slave  (input start, input txt, output busy, output valid, output hash);
endinterface

// File: rtl/md5_core.sv
// rtl/md5_core.sv - single-block MD5 of a fixed 8-byte message, UNROLL rounds per clock
module md5_core #(
    parameter int UNROLL = 1
) (
    input  logic      clk,
    input  logic      reset_n,
    md5_core_if.slave bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;

    localparam logic [31:0] IV_A = 32'h67452301;
    localparam logic [31:0] IV_B = 32'hefcdab89;
    localparam logic [31:0] IV_C = 32'h98badcfe;
    localparam logic [31:0] IV_D = 32'h10325476;

    function automatic logic [31:0] k_rom(input logic [5:0] i);
        logic [31:0] k;
        k = 32'h0;
        case (i)
            6'd0:  k = 32'hd76aa478;  6'd1:  k = 32'he8c7b756;  6'd2:  k = 32'h242070db;  6'd3:  k = 32'hc1bdceee;
            6'd4:  k = 32'hf57c0faf;  6'd5:  k = 32'h4787c62a;  6'd6:  k = 32'ha8304613;  6'd7:  k = 32'hfd469501;
            6'd8:  k = 32'h698098d8;  6'd9:  k = 32'h8b44f7af;  6'd10: k = 32'hffff5bb1;  6'd11: k = 32'h895cd7be;
            6'd12: k = 32'h6b901122;  6'd13: k = 32'hfd987193;  6'd14: k = 32'ha679438e;  6'd15: k = 32'h49b40821;
            6'd16: k = 32'hf61e2562;  6'd17: k = 32'hc040b340;  6'd18: k = 32'h265e5a51;  6'd19: k = 32'he9b6c7aa;
            6'd20: k = 32'hd62f105d;  6'd21: k = 32'h02441453;  6'd22: k = 32'hd8a1e681;  6'd23: k = 32'he7d3fbc8;
            6'd24: k = 32'h21e1cde6;  6'd25: k = 32'hc33707d6;  6'd26: k = 32'hf4d50d87;  6'd27: k = 32'h455a14ed;
            6'd28: k = 32'ha9e3e905;  6'd29: k = 32'hfcefa3f8;  6'd30: k = 32'h676f02d9;  6'd31: k = 32'h8d2a4c8a;
            6'd32: k = 32'hfffa3942;  6'd33: k = 32'h8771f681;  6'd34: k = 32'h6d9d6122;  6'd35: k = 32'hfde5380c;
            6'd36: k = 32'ha4beea44;  6'd37: k = 32'h4bdecfa9;  6'd38: k = 32'hf6bb4b60;  6'd39: k = 32'hbebfbc70;
            6'd40: k = 32'h289b7ec6;  6'd41: k = 32'heaa127fa;  6'd42: k = 32'hd4ef3085;  6'd43: k = 32'h04881d05;
            6'd44: k = 32'hd9d4d039;  6'd45: k = 32'he6db99e5;  6'd46: k = 32'h1fa27cf8;  6'd47: k = 32'hc4ac5665;
            6'd48: k = 32'hf4292244;  6'd49: k = 32'h432aff97;  6'd50: k = 32'hab9423a7;  6'd51: k = 32'hfc93a039;
            6'd52: k = 32'h655b59c3;  6'd53: k = 32'h8f0ccc92;  6'd54: k = 32'hffeff47d;  6'd55: k = 32'h85845dd1;
            6'd56: k = 32'h6fa87e4f;  6'd57: k = 32'hfe2ce6e0;  6'd58: k = 32'ha3014314;  6'd59: k = 32'h4e0811a1;
            6'd60: k = 32'hf7537e82;  6'd61: k = 32'hbd3af235;  6'd62: k = 32'h2ad7d2bb;  6'd63: k = 32'heb86d391;
            default: k = 32'h0;
        endcase
        return k;
    endfunction

    function automatic logic [4:0] s_rom(input logic [5:0] i);
        logic [4:0] s;
        s = 5'd0;
        case ({i[5:4], i[1:0]})
            4'h0: s = 5'd7;   4'h1: s = 5'd12;  4'h2: s = 5'd17;  4'h3: s = 5'd22;
            4'h4: s = 5'd5;   4'h5: s = 5'd9;   4'h6: s = 5'd14;  4'h7: s = 5'd20;
            4'h8: s = 5'd4;   4'h9: s = 5'd11;  4'ha: s = 5'd16;  4'hb: s = 5'd23;
            4'hc: s = 5'd6;   4'hd: s = 5'd10;  4'he: s = 5'd15;  4'hf: s = 5'd21;
            default: s = 5'd0;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Only M0, M1, M2 and M14 are non-zero for an 8-byte message.
    function automatic logic [127:0] md5_round(input logic [127:0] st, input logic [5:0] i,
                                               input logic [31:0] m0, input logic [31:0] m1);
        logic [31:0] a, b, c, d, f, mw, sum;
        logic [3:0]  g;
        logic [63:0] dbl;
        {a, b, c, d} = st;
        case (i[5:4])
            2'd0:    begin f = (b & c) | (~b & d); g = i[3:0];                end
            2'd1:    begin f = (b & d) | (c & ~d); g = i[3:0] * 4'd5 + 4'd1;  end
            2'd2:    begin f = b ^ c ^ d;          g = i[3:0] * 4'd3 + 4'd5;  end
            default: begin f = c ^ (b | ~d);       g = i[3:0] * 4'd7;         end
        endcase
        case (g)
            4'd0:    mw = m0;
            4'd1:    mw = m1;
            4'd2:    mw = 32'h00000080;
            4'd14:   mw = 32'h00000040;
            default: mw = 32'h0;
        endcase
        sum = a + f + k_rom(i) + mw;
        dbl = {sum, sum} << s_rom(i);
        return {d, b + dbl[63:32], b, c};
    endfunction

    logic [1:0]   state_q, state_d;
    logic [5:0]   cnt_q, cnt_d;
    logic [31:0]  a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic [63:0]  txt_q, txt_d;
    logic         busy_q, busy_d;
    logic         valid_q, valid_d;
    logic [127:0] hash_q, hash_d;

    logic [31:0]  m0, m1;
    logic [127:0] rounds_out;

    assign m0 = {txt_q[39:32], txt_q[47:40], txt_q[55:48], txt_q[63:56]};
    assign m1 = {txt_q[7:0], txt_q[15:8], txt_q[23:16], txt_q[31:24]};

    for (genvar u = 0; u < UNROLL; u++) begin : g_stage
        logic [127:0] st_in;
        logic [127:0] st_out;
        if (u == 0) begin : g_first
            assign st_in = {a_q, b_q, c_q, d_q};
        end else begin : g_next
            assign st_in = g_stage[u-1].st_out;
        end
        assign st_out = md5_round(st_in, cnt_q + 6'(u), m0, m1);
    end

    assign rounds_out = g_stage[UNROLL-1].st_out;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        txt_d   = txt_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        hash_d  = hash_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_ROUND;
                    txt_d   = bus.txt;
                    a_d     = IV_A;
                    b_d     = IV_B;
                    c_d     = IV_C;
                    d_d     = IV_D;
                    cnt_d   = 6'd0;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                end
            end
            S_ROUND: begin
                {a_d, b_d, c_d, d_d} = rounds_out;
                cnt_d = cnt_q + 6'(UNROLL);
                if (({1'b0, cnt_q} + 7'(UNROLL)) == 7'd64) begin
                    state_d = S_FINAL;
                end
            end
            S_FINAL: begin
                hash_d  = {bswap(a_q + IV_A), bswap(b_q + IV_B), bswap(c_q + IV_C), bswap(d_q + IV_D)};
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            a_q     <= 32'h0;
            b_q     <= 32'h0;
            c_q     <= 32'h0;
            d_q     <= 32'h0;
            txt_q   <= 64'h0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            hash_q  <= 128'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            txt_q   <= txt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            hash_q  <= hash_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;
    assign bus.hash  = hash_q;

endmodule

// File: tb/tb_md5_core.sv
// tb/tb_md5_core.sv - checks md5_core at UNROLL 1, 2 and 4 against a reference MD5 model
module tb_md5_core;

    localparam logic [127:0] H_ZEROS = 128'hdd4b21e9ef71e1291183a46b913ae6f2;
    localparam logic [127:0] H_DIGIT = 128'h25d55ad283aa400af464c76d713c07ad;
    localparam logic [127:0] H_PASSW = 128'h5f4dcc3b5aa765d61d8327deb882cf99;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [63:0]  txt;
    logic         busy_w  [3];
    logic         valid_w [3];
    logic [127:0] hash_w  [3];

    int errs;
    int checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        md5_core_if ifc ();
        assign ifc.start  = start;
        assign ifc.txt    = txt;
        assign busy_w[k]  = ifc.busy;
        assign valid_w[k] = ifc.valid;
        assign hash_w[k]  = ifc.hash;
        md5_core #(.UNROLL(1 << k)) dut (.clk(clk), .reset_n(reset_n), .bus(ifc));
    end

    // Textbook MD5 of one padded 64-byte block; K comes from |sin(i+1)| * 2^32.
    function automatic logic [127:0] md5_ref(input logic [63:0] t);
        logic [7:0]  msg [64];
        logic [31:0] w   [16];
        logic [31:0] a, b, c, d, f, x, tmp, kt;
        logic [31:0] h [4];
        logic [127:0] out;
        longint kl;
        real r;
        int g, sh, q;
        for (int j = 0; j < 64; j++) msg[j] = 8'h00;
        for (int j = 0; j < 8; j++) msg[j] = t[63-8*j -: 8];
        msg[8]  = 8'h80;
        msg[56] = 8'd64;
        for (int j = 0; j < 16; j++) w[j] = {msg[4*j+3], msg[4*j+2], msg[4*j+1], msg[4*j]};
        h[0] = 32'h67452301; h[1] = 32'hefcdab89; h[2] = 32'h98badcfe; h[3] = 32'h10325476;
        a = h[0]; b = h[1]; c = h[2]; d = h[3];
        for (int i = 0; i < 64; i++) begin
            q = i % 4;
            case (i / 16)
                0: begin f = (b & c) | (~b & d); g = i;                sh = (q == 0) ? 7 : (q == 1) ? 12 : (q == 2) ? 17 : 22; end
                1: begin f = (b & d) | (c & ~d); g = (5 * i + 1) % 16; sh = (q == 0) ? 5 : (q == 1) ? 9  : (q == 2) ? 14 : 20; end
                2: begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; sh = (q == 0) ? 4 : (q == 1) ? 11 : (q == 2) ? 16 : 23; end
                default: begin f = c ^ (b | ~d); g = (7 * i) % 16;    sh = (q == 0) ? 6 : (q == 1) ? 10 : (q == 2) ? 15 : 21; end
            endcase
            r = $sin(real'(i + 1));
            if (r < 0.0) r = -r;
            kl = longint'($floor(r * 4294967296.0));
            kt = kl[31:0];
            x = a + f + kt + w[g];
            tmp = d; d = c; c = b;
            b = b + ((x << sh) | (x >> (32 - sh)));
            a = tmp;
        end
        h[0] = h[0] + a; h[1] = h[1] + b; h[2] = h[2] + c; h[3] = h[3] + d;
        for (int j = 0; j < 16; j++) out[127-8*j -: 8] = h[j/4][8*(j%4) +: 8];
        return out;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    bit         m_run   [3];
    bit         m_pend  [3];
    bit         m_valid [3];
    int         m_left  [3];
    bit [63:0]  m_cur   [3];
    bit [63:0]  m_ptxt  [3];
    bit [127:0] m_hash  [3];

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!reset_n) begin
                m_run[k] = 1'b0; m_pend[k] = 1'b0; m_valid[k] = 1'b0;
                m_left[k] = 0; m_hash[k] = '0;
            end else if (m_pend[k]) begin
                m_run[k] = 1'b1; m_pend[k] = 1'b0; m_valid[k] = 1'b0;
                m_left[k] = 64 / (1 << k) + 1; m_cur[k] = m_ptxt[k];
            end else if (m_run[k]) begin
                m_left[k]--;
                if (m_left[k] == 0) begin
                    m_run[k] = 1'b0; m_valid[k] = 1'b1; m_hash[k] = md5_ref(m_cur[k]);
                end
            end
            check($sformatf("u%0d.busy", 1 << k), 128'(busy_w[k]), 128'(m_run[k]));
            check($sformatf("u%0d.valid", 1 << k), 128'(valid_w[k]), 128'(m_valid[k]));
            check($sformatf("u%0d.hash", 1 << k), hash_w[k], m_hash[k]);
            m_pend[k] = reset_n && start && !m_run[k];
            m_ptxt[k] = txt;
        end
    end

    task automatic run_one(input logic [63:0] v, input logic [127:0] lit);
        int lat [3];
        @(posedge clk); #1;
        start = 1'b1; txt = v;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 3; k++) lat[k] = 0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) if (valid_w[k] && lat[k] == 0) lat[k] = cyc;
        end
        check("model_literal", md5_ref(v), lit);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("u%0d.latency", 1 << k), 128'(lat[k]), 128'(64 / (1 << k) + 1));
            check($sformatf("u%0d.digest_literal", 1 << k), hash_w[k], lit);
        end
    endtask

    initial begin
        errs = 0; checks = 0;
        reset_n = 1'b0; start = 1'b0; txt = 64'h0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        run_one("00000000", H_ZEROS);
        run_one("12345678", H_DIGIT);
        run_one("password", H_PASSW);

        // Second request 10 cycles into a computation must be dropped.
        @(posedge clk); #1;
        start = 1'b1; txt = "12345678";
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1; txt = "password";
        @(posedge clk); #1;
        start = 1'b0;
        repeat (75) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) check($sformatf("u%0d.ignored_start", 1 << k), hash_w[k], H_DIGIT);

        // start held high while txt changes every cycle.
        @(posedge clk); #1;
        start = 1'b1;
        for (int c = 0; c < 300; c++) begin
            txt = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (80) @(posedge clk);

        // Reset in the middle of round 30.
        #1;
        start = 1'b1; txt = "00000000";
        @(posedge clk); #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("reset.busy", 128'(busy_w[0]), 128'(0));
        check("reset.valid", 128'(valid_w[0]), 128'(0));
        check("reset.hash", hash_w[0], 128'h0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        run_one("12345678", H_DIGIT);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
